elastic_skid: RTL

Reverse-registered elastic stage: a two-entry valid/ready buffer that registers `valid_o`, `data_o` **and** `ready_o`. There is no combinational path from `ready_i` to `ready_o`, which breaks the backpressure timing path that a forward-only elastic stage leaves open. It sits between producers and consumers wherever long ready chains limit Fmax. It can be chained with forward elastic stages, and sustains full throughput (one beat per cycle).

---
 rtl/elastic_skid.sv | 118 +++++++++++
 1 files changed

// File: rtl/elastic_skid.sv
// elastic_skid: two-entry valid/ready buffer with registered valid, data and ready.
// A main register drives data_o and a skid register absorbs the one extra beat
// that can arrive in the cycle after the downstream stalls. Because ready_o comes
// only from the state register, ready_i never reaches ready_o combinationally.
module elastic_skid #(
   parameter int width_p          = 8,
   parameter int datapath_gate_p  = 0,
   parameter int datapath_reset_p = 0
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [width_p-1:0] data_i,
   input  logic               valid_i,
   output logic               ready_o,
   output logic               valid_o,
   output logic [width_p-1:0] data_o,
   input  logic               ready_i,
   output logic [1:0]         count_o
);

   // The state encoding is the occupancy, so count_o is the state register itself.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [width_p-1:0] main_q, main_d;
   logic [width_p-1:0] skid_q, skid_d;
   logic               in_xfer, out_xfer;
   logic               main_ld, skid_ld, main_from_skid;
   logic               main_en, skid_en;

   assign ready_o  = !reset_i && (state_q != ST_FULL);
   assign valid_o  = (state_q != ST_EMPTY);
   assign data_o   = main_q;
   assign count_o  = state_q;

   assign in_xfer  = valid_i && ready_o;
   assign out_xfer = valid_o && ready_i;

   // Next-state and load-slot decode; reset overrides everything back to EMPTY.
   always_comb begin
      state_d        = state_q;
      main_ld        = 1'b0;
      skid_ld        = 1'b0;
      main_from_skid = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (in_xfer) begin
               state_d = ST_BUSY;
               main_ld = 1'b1;
            end
         end
         ST_BUSY: begin
            if (in_xfer && out_xfer) begin
               main_ld = 1'b1;
            end else if (in_xfer) begin
               state_d = ST_FULL;
               skid_ld = 1'b1;
            end else if (out_xfer) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_xfer) begin
               state_d        = ST_BUSY;
               main_ld        = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (reset_i) begin
         state_d = ST_EMPTY;
      end
   end

   // Ungated mode lets main track data_i while empty and skid track it while busy;
   // those contents are never observed, so the loads only need to be right on handshakes.
   always_comb begin
      main_d = main_from_skid ? skid_q : data_i;
      skid_d = data_i;
      if (datapath_gate_p != 0) begin
         main_en = main_ld;
         skid_en = skid_ld;
      end else begin
         main_en = main_ld || (state_q == ST_EMPTY);
         skid_en = (state_q == ST_BUSY);
      end
   end

   // Control state register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Payload registers; cleared on reset only when datapath reset is enabled.
   always_ff @(posedge clk_i) begin
      if ((datapath_reset_p != 0) && reset_i) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (main_en) begin
            main_q <= main_d;
         end
         if (skid_en) begin
            skid_q <= skid_d;
         end
      end
   end

endmodule
